// File: rtl/pll_reconfig_ctrl.sv
// Loads a SCAN_LEN-bit image into the PLL scan chain, strobes configupdate, then resets the PLL and waits for lock; start is ignored while busy.
// Latency 1 + 2*CLKDIV*(SCAN_LEN+1) + scandone wait + ARESET_CYCLES + lock wait; RECONF_READBACK_EN adds scan-chain readback.
module pll_reconfig_ctrl #(
   parameter int SCAN_LEN      = 144,
   parameter int CLKDIV        = 2,
   parameter int TIMEOUT       = 4096,
   parameter int ARESET_CYCLES = 8
) (
   input  logic                osc_clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SCAN_LEN-1:0] scan_image,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                scanclk,
   output logic                scanclkena,
   output logic                scandata,
   output logic                configupdate,
   input  logic                scandone,
   output logic                pll_areset,
   input  logic                locked
`ifdef RECONF_READBACK_EN
   ,
   input  logic                scandataout,
   output logic [SCAN_LEN-1:0] readback,
   output logic                readback_valid
`endif
);

   localparam int BIT_W    = $clog2(SCAN_LEN + 1);
   localparam int DIV_W    = $clog2(CLKDIV + 1);
   localparam int TMO_W    = $clog2(TIMEOUT + 1);
   localparam int HOLD_MAX = (2 * CLKDIV > ARESET_CYCLES) ? 2 * CLKDIV : ARESET_CYCLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_UPDATE, S_WAIT_DONE, S_PLL_RST, S_WAIT_LOCK, S_DONE, S_ERR
   } state_t;

   state_t              state, state_nxt;
   logic [SCAN_LEN-1:0] sr;
   logic [BIT_W-1:0]    bit_cnt;
   logic [DIV_W-1:0]    div_cnt;
   logic                sclk_ph;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                err_q;
   logic [1:0]          sd_sync;
   logic [1:0]          lk_sync;
   logic                div_end;
   logic                last_bit;
   logic                tmo_hit;

   assign div_end  = (div_cnt == DIV_W'(CLKDIV - 1));
   assign last_bit = (bit_cnt == BIT_W'(SCAN_LEN - 1));
   assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT));

   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      done         = 1'b0;
      error        = err_q;
      scanclkena   = 1'b0;
      scanclk      = 1'b0;
      scandata     = 1'b0;
      configupdate = 1'b0;
      pll_areset   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            busy       = 1'b1;
            scanclkena = 1'b1;
            scanclk    = sclk_ph;
            scandata   = sr[SCAN_LEN-1];
            // leave only after the high phase of the last bit completes
            if (sclk_ph && div_end && last_bit) state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            busy         = 1'b1;
            configupdate = 1'b1;
            if (hold_cnt == HOLD_W'(2 * CLKDIV - 1)) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            busy = 1'b1;
            if (sd_sync[1])   state_nxt = S_PLL_RST;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_PLL_RST: begin
            busy       = 1'b1;
            pll_areset = 1'b1;
            if (hold_cnt == HOLD_W'(ARESET_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            busy = 1'b1;
            if (lk_sync[1])   state_nxt = S_DONE;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge osc_clk) begin
      if (reset) begin
         state    <= S_IDLE;
         sr       <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         sclk_ph  <= 1'b0;
         tmo_cnt  <= '0;
         hold_cnt <= '0;
         err_q    <= 1'b0;
         sd_sync  <= '0;
         lk_sync  <= '0;
      end else begin
         state   <= state_nxt;
         sd_sync <= {sd_sync[0], scandone};
         lk_sync <= {lk_sync[0], locked};
         // both timers restart on every state change and saturate rather than wrap
         if (state_nxt != state) begin
            tmo_cnt  <= '0;
            hold_cnt <= '0;
         end else begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            if (hold_cnt != HOLD_W'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
         end
         if (state == S_IDLE && start) begin
            sr      <= scan_image;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk_ph <= 1'b0;
            err_q   <= 1'b0;
         end else if (state == S_SHIFT) begin
            if (div_end) begin
               div_cnt <= '0;
               sclk_ph <= ~sclk_ph;
               if (sclk_ph) begin
                  sr      <= sr << 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
         if (state_nxt == S_ERR) err_q <= 1'b1;
      end
   end

`ifdef RECONF_READBACK_EN
   logic [SCAN_LEN-1:0] rb_sr;

   // samples land in the LSB so the first bit ends up in the MSB
   always_ff @(posedge osc_clk) begin
      if (reset) begin
         rb_sr          <= '0;
         readback       <= '0;
         readback_valid <= 1'b0;
      end else begin
         readback_valid <= 1'b0;
         if (state == S_IDLE && start) begin
            rb_sr <= '0;
         end else if (state == S_SHIFT && !sclk_ph && div_end) begin
            rb_sr <= (rb_sr << 1) | SCAN_LEN'(scandataout);
         end
         if (state == S_SHIFT && state_nxt == S_UPDATE) begin
            readback       <= rb_sr;
            readback_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: a negedge monitor tallies scan-port activity and each
// reconfiguration run compares the tallies against hand-derived counts.
module tb_pll_reconfig_ctrl;

   localparam int SCAN_LEN      = 144;
   localparam int CLKDIV        = 2;
   localparam int TIMEOUT       = 4096;
   localparam int ARESET_CYCLES = 8;

   localparam int W_CU_HI = 0;
   localparam int W_CU_LO = 1;
   localparam int W_AR_HI = 2;
   localparam int W_AR_LO = 3;
   localparam int W_END   = 4;

   logic                osc_clk    = 1'b0;
   logic                reset      = 1'b1;
   logic                start      = 1'b0;
   logic [SCAN_LEN-1:0] scan_image = '0;
   logic                scandone   = 1'b0;
   logic                locked     = 1'b0;
   logic                busy, done, error, scanclk, scanclkena, scandata, configupdate, pll_areset;

   logic [SCAN_LEN-1:0] img_a = {18{8'hA5}};
   logic [SCAN_LEN-1:0] img_b = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD;
   logic [SCAN_LEN-1:0] img_c = {9{16'h8001}};

`ifdef RECONF_READBACK_EN
   logic                scandataout;
   logic [SCAN_LEN-1:0] readback;
   logic                readback_valid;
   logic [SCAN_LEN-1:0] rb_pat = {9{16'hC3F0}};
   int                  rise_base = 0;
   int                  rb_idx;
   logic [7:0]          rb_bit;
`endif

   int n_total = 0;
   int n_bad   = 0;

   int rise_cnt = 0, sclk_hi = 0, ena_hi = 0, cu_hi = 0, ar_hi = 0;
   int done_cnt = 0, done_busy = 0, err_hi = 0, viol = 0, rbv_cnt = 0;
   logic prev_sclk = 1'b0;
   logic prev_sdat = 1'b0;
   logic [SCAN_LEN-1:0] cap = '0;

   always #5 osc_clk = ~osc_clk;

   pll_reconfig_ctrl #(
      .SCAN_LEN(SCAN_LEN), .CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT), .ARESET_CYCLES(ARESET_CYCLES)
   ) dut (
      .osc_clk(osc_clk),
      .reset(reset),
      .start(start),
      .scan_image(scan_image),
      .busy(busy),
      .done(done),
      .error(error),
      .scanclk(scanclk),
      .scanclkena(scanclkena),
      .scandata(scandata),
      .configupdate(configupdate),
      .scandone(scandone),
      .pll_areset(pll_areset),
      .locked(locked)
`ifdef RECONF_READBACK_EN
      ,
      .scandataout(scandataout),
      .readback(readback),
      .readback_valid(readback_valid)
`endif
   );

`ifdef RECONF_READBACK_EN
   // PLL model: presents pattern bit k (MSB first) until the k-th scanclk rise has been seen
   assign rb_idx      = rise_cnt - rise_base;
   assign rb_bit      = 8'(SCAN_LEN - 1 - rb_idx);
   assign scandataout = (rb_idx >= 0 && rb_idx < SCAN_LEN) ? rb_pat[rb_bit] : 1'b0;
`endif

   always @(negedge osc_clk) begin
      prev_sclk <= scanclk;
      prev_sdat <= scandata;
      if (scanclk && !prev_sclk) begin
         rise_cnt <= rise_cnt + 1;
         cap      <= {cap[SCAN_LEN-2:0], scandata};
      end
      if (scanclk) sclk_hi <= sclk_hi + 1;
      if (scanclkena) ena_hi <= ena_hi + 1;
      if (scanclk && prev_sclk && scandata != prev_sdat) viol <= viol + 1;
      if (configupdate) cu_hi <= cu_hi + 1;
      if (pll_areset) ar_hi <= ar_hi + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (done && busy) done_busy <= done_busy + 1;
      if (error) err_hi <= err_hi + 1;
`ifdef RECONF_READBACK_EN
      if (readback_valid) rbv_cnt <= rbv_cnt + 1;
`endif
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_for(input int sel, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge osc_clk);
         case (sel)
            W_CU_HI: ok = configupdate;
            W_CU_LO: ok = !configupdate;
            W_AR_HI: ok = pll_areset;
            W_AR_LO: ok = !pll_areset;
            default: ok = done || error;
         endcase
      end
   endtask

   task automatic run(input logic [SCAN_LEN-1:0] img, input bit give_done, input bit give_lock,
                      input int poke_at, input bit exp_err, input int exp_ar);
      bit ok;
      int b_rise, b_shi, b_ena, b_cu, b_ar, b_done, b_db, b_err, b_viol, b_rbv;
      scandone   = 1'b0;
      locked     = 1'b0;
      scan_image = img;
      start      = 1'b1;
      @(negedge osc_clk);
      start      = 1'b0;
      scan_image = ~img;
      check("busy_on", 160'(busy), 160'(1));
      check("err_clr", 160'(error), 160'(0));
      b_rise = rise_cnt; b_shi = sclk_hi; b_ena = ena_hi; b_cu = cu_hi; b_ar = ar_hi;
      b_done = done_cnt; b_db = done_busy; b_err = err_hi; b_viol = viol; b_rbv = rbv_cnt;
`ifdef RECONF_READBACK_EN
      rise_base = rise_cnt;
`endif
      if (poke_at > 0) begin
         for (int i = 0; i < 4000 && (rise_cnt - b_rise) < poke_at; i++) @(negedge osc_clk);
         start = 1'b1;
         @(negedge osc_clk);
         start = 1'b0;
      end
      wait_for(W_CU_HI, 2000, ok);
      check("cu_seen", 160'(ok), 160'(1));
      wait_for(W_CU_LO, 100, ok);
      check("cu_fall", 160'(ok), 160'(1));
      if (give_done) begin
         repeat (10) @(negedge osc_clk);
         scandone = 1'b1;
         wait_for(W_AR_HI, 100, ok);
         check("ar_seen", 160'(ok), 160'(1));
         wait_for(W_AR_LO, 100, ok);
         check("ar_fall", 160'(ok), 160'(1));
         if (give_lock) begin
            repeat (20) @(negedge osc_clk);
            locked = 1'b1;
         end
      end
      wait_for(W_END, 6000, ok);
      check("end_seen", 160'(ok), 160'(1));
      check("busy_end", 160'(busy), 160'(0));
      check("err_end", 160'(error), 160'(exp_err));
      repeat (2) @(negedge osc_clk);
      check("err_sticky", 160'(error), 160'(exp_err));
      check("rises", 160'(rise_cnt - b_rise), 160'(SCAN_LEN));
      check("image", 160'(cap), 160'(img));
      check("sclk_hi", 160'(sclk_hi - b_shi), 160'(CLKDIV * SCAN_LEN));
      check("ena_hi", 160'(ena_hi - b_ena), 160'(2 * CLKDIV * SCAN_LEN));
      check("dat_stable", 160'(viol - b_viol), 160'(0));
      check("cu_len", 160'(cu_hi - b_cu), 160'(2 * CLKDIV));
      check("ar_len", 160'(ar_hi - b_ar), 160'(exp_ar));
      check("done_cnt", 160'(done_cnt - b_done), 160'(exp_err ? 0 : 1));
      check("done_busy", 160'(done_busy - b_db), 160'(0));
      if (!exp_err) check("err_quiet", 160'(err_hi - b_err), 160'(0));
`ifdef RECONF_READBACK_EN
      check("readback", 160'(readback), 160'(rb_pat));
      check("rb_valid", 160'(rbv_cnt - b_rbv), 160'(1));
`else
      check("no_rbv", 160'(rbv_cnt - b_rbv), 160'(0));
`endif
      scandone = 1'b0;
   endtask

   initial begin
      int b;
      // reset held with start high: nothing may move
      reset      = 1'b1;
      start      = 1'b1;
      scan_image = img_a;
      repeat (5) @(negedge osc_clk);
      check("rst_outs", 160'({busy, done, error, scanclk, scanclkena, configupdate, pll_areset}), 160'(0));
      check("rst_busy", 160'(busy), 160'(0));
      check("rst_rises", 160'(rise_cnt), 160'(0));
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge osc_clk);
      check("idle_busy", 160'(busy), 160'(0));

      run(img_a, 1'b1, 1'b1, 0, 1'b0, ARESET_CYCLES);   // nominal reconfiguration
      run(img_b, 1'b0, 1'b0, 0, 1'b1, 0);               // scandone never arrives
      run(img_c, 1'b1, 1'b0, 0, 1'b1, ARESET_CYCLES);   // lock never arrives
      run(img_a, 1'b1, 1'b1, 0, 1'b0, ARESET_CYCLES);   // recovers, error stays low
      run(img_b, 1'b1, 1'b1, 10, 1'b0, ARESET_CYCLES);  // second start mid-shift ignored

      // reset in the middle of the shift at bit 70
      scan_image = img_a;
      start      = 1'b1;
      @(negedge osc_clk);
      start = 1'b0;
      b     = rise_cnt;
      for (int i = 0; i < 2000 && (rise_cnt - b) < 70; i++) @(negedge osc_clk);
      check("abort_bit", 160'(rise_cnt - b), 160'(70));
      reset = 1'b1;
      @(negedge osc_clk);
      check("abort_outs", 160'({busy, done, error, scanclk, scanclkena, scandata, configupdate, pll_areset}), 160'(0));
      reset = 1'b0;
      repeat (2) @(negedge osc_clk);
      b = rise_cnt;
      repeat (20) @(negedge osc_clk);
      check("abort_quiet", 160'(rise_cnt - b), 160'(0));
      check("abort_idle", 160'(busy), 160'(0));

      run(img_c, 1'b1, 1'b1, 0, 1'b0, ARESET_CYCLES);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
